// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: 1-cycle registered control/operand bundle to EX.
// stall holds every field; flush (over stall) or an invalid load inserts a counted bubble.
module id_ex_pipeline_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic                      branch_in,
  input  logic                      memRead_in,
  input  logic                      memToReg_in,
  input  logic                      memWrite_in,
  input  logic [1:0]                aluOp_in,
  input  logic                      aluSRC_in,
  input  logic                      regWrite_in,
  input  logic [PC_WIDTH-1:0]       pc_in,
  input  logic [DATA_WIDTH-1:0]     readData1_in,
  input  logic [DATA_WIDTH-1:0]     readData2_in,
  input  logic [DATA_WIDTH-1:0]     imm_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs_in,
  input  logic [REG_ADDR_WIDTH-1:0] rt_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic                      valid_ex,
  output logic                      branch_ex,
  output logic                      memRead_ex,
  output logic                      memToReg_ex,
  output logic                      memWrite_ex,
  output logic [1:0]                aluOp_ex,
  output logic                      aluSRC_ex,
  output logic                      regWrite_ex,
  output logic [PC_WIDTH-1:0]       pc_ex,
  output logic [DATA_WIDTH-1:0]     readData1_ex,
  output logic [DATA_WIDTH-1:0]     readData2_ex,
  output logic [DATA_WIDTH-1:0]     imm_ex,
  output logic [REG_ADDR_WIDTH-1:0] rs_ex,
  output logic [REG_ADDR_WIDTH-1:0] rt_ex,
  output logic [REG_ADDR_WIDTH-1:0] rd_ex,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 bubble;
  logic [CNT_WIDTH-1:0] count_next;

  // A bubble is counted on a flush or on an unstalled load of an invalid slot.
  always_comb begin
    bubble     = flush | (~stall & ~valid_in);
    count_next = bubble_count;
    if (bubble && bubble_count != CNT_MAX) begin
      count_next = bubble_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ex     <= 1'b0;
      branch_ex    <= 1'b0;
      memRead_ex   <= 1'b0;
      memToReg_ex  <= 1'b0;
      memWrite_ex  <= 1'b0;
      aluOp_ex     <= 2'b00;
      aluSRC_ex    <= 1'b0;
      regWrite_ex  <= 1'b0;
      pc_ex        <= '0;
      readData1_ex <= '0;
      readData2_ex <= '0;
      imm_ex       <= '0;
      rs_ex        <= '0;
      rt_ex        <= '0;
      rd_ex        <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      valid_ex     <= 1'b0;
      branch_ex    <= 1'b0;
      memRead_ex   <= 1'b0;
      memToReg_ex  <= 1'b0;
      memWrite_ex  <= 1'b0;
      aluOp_ex     <= 2'b00;
      aluSRC_ex    <= 1'b0;
      regWrite_ex  <= 1'b0;
      pc_ex        <= '0;
      readData1_ex <= '0;
      readData2_ex <= '0;
      imm_ex       <= '0;
      rs_ex        <= '0;
      rt_ex        <= '0;
      rd_ex        <= '0;
      bubble_count <= count_next;
    end else if (!stall) begin
      // Control is gated by valid_in so an invalid slot never carries live control.
      valid_ex     <= valid_in;
      branch_ex    <= branch_in & valid_in;
      memRead_ex   <= memRead_in & valid_in;
      memToReg_ex  <= memToReg_in & valid_in;
      memWrite_ex  <= memWrite_in & valid_in;
      aluOp_ex     <= aluOp_in & {2{valid_in}};
      aluSRC_ex    <= aluSRC_in & valid_in;
      regWrite_ex  <= regWrite_in & valid_in;
      pc_ex        <= pc_in;
      readData1_ex <= readData1_in;
      readData2_ex <= readData2_in;
      imm_ex       <= imm_in;
      rs_ex        <= rs_in;
      rt_ex        <= rt_in;
      rd_ex        <= rd_in;
      bubble_count <= count_next;
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, valid_in;
  logic        branch_in, memRead_in, memToReg_in, memWrite_in, aluSRC_in, regWrite_in;
  logic [1:0]  aluOp_in;
  logic [31:0] pc_in, readData1_in, readData2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;

  logic        valid_ex, branch_ex, memRead_ex, memToReg_ex, memWrite_ex, aluSRC_ex, regWrite_ex;
  logic [1:0]  aluOp_ex;
  logic [31:0] pc_ex, readData1_ex, readData2_ex, imm_ex;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic [15:0] bubble_count;

  logic        d4_valid_ex, d4_branch_ex, d4_memRead_ex, d4_memToReg_ex, d4_memWrite_ex;
  logic        d4_aluSRC_ex, d4_regWrite_ex;
  logic [1:0]  d4_aluOp_ex;
  logic [31:0] d4_pc_ex, d4_readData1_ex, d4_readData2_ex, d4_imm_ex;
  logic [4:0]  d4_rs_ex, d4_rt_ex, d4_rd_ex;
  logic [3:0]  d4_bubble_count;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .branch_in(branch_in), .memRead_in(memRead_in), .memToReg_in(memToReg_in),
    .memWrite_in(memWrite_in), .aluOp_in(aluOp_in), .aluSRC_in(aluSRC_in),
    .regWrite_in(regWrite_in), .pc_in(pc_in), .readData1_in(readData1_in),
    .readData2_in(readData2_in), .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .valid_ex(valid_ex), .branch_ex(branch_ex), .memRead_ex(memRead_ex),
    .memToReg_ex(memToReg_ex), .memWrite_ex(memWrite_ex), .aluOp_ex(aluOp_ex),
    .aluSRC_ex(aluSRC_ex), .regWrite_ex(regWrite_ex), .pc_ex(pc_ex),
    .readData1_ex(readData1_ex), .readData2_ex(readData2_ex), .imm_ex(imm_ex),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .bubble_count(bubble_count)
  );

  id_ex_pipeline_reg #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .branch_in(branch_in), .memRead_in(memRead_in), .memToReg_in(memToReg_in),
    .memWrite_in(memWrite_in), .aluOp_in(aluOp_in), .aluSRC_in(aluSRC_in),
    .regWrite_in(regWrite_in), .pc_in(pc_in), .readData1_in(readData1_in),
    .readData2_in(readData2_in), .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .valid_ex(d4_valid_ex), .branch_ex(d4_branch_ex), .memRead_ex(d4_memRead_ex),
    .memToReg_ex(d4_memToReg_ex), .memWrite_ex(d4_memWrite_ex), .aluOp_ex(d4_aluOp_ex),
    .aluSRC_ex(d4_aluSRC_ex), .regWrite_ex(d4_regWrite_ex), .pc_ex(d4_pc_ex),
    .readData1_ex(d4_readData1_ex), .readData2_ex(d4_readData2_ex), .imm_ex(d4_imm_ex),
    .rs_ex(d4_rs_ex), .rt_ex(d4_rt_ex), .rd_ex(d4_rd_ex), .bubble_count(d4_bubble_count)
  );

  typedef struct {
    logic        valid, branch, memRead, memToReg, memWrite, aluSRC, regWrite;
    logic [1:0]  aluOp;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t model;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z = '{valid: 1'b0, branch: 1'b0, memRead: 1'b0, memToReg: 1'b0, memWrite: 1'b0,
          aluSRC: 1'b0, regWrite: 1'b0, aluOp: 2'b00, pc: '0, rd1: '0, rd2: '0,
          imm: '0, rs: '0, rt: '0, rd: '0, cnt: '0, cnt4: '0};
    return z;
  endfunction

  function automatic exp_t count_bubble(input exp_t s);
    exp_t n = s;
    if (n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
    if (n.cnt4 != 4'hF) n.cnt4 = n.cnt4 + 4'd1;
    return n;
  endfunction

  // Reference for one clock edge, evaluated from the inputs presented to it.
  function automatic exp_t next_state(input exp_t s);
    exp_t n = s;
    if (flush) begin
      n = zero_state();
      n.cnt  = s.cnt;
      n.cnt4 = s.cnt4;
      n = count_bubble(n);
    end else if (!stall) begin
      n.pc = pc_in; n.rd1 = readData1_in; n.rd2 = readData2_in; n.imm = imm_in;
      n.rs = rs_in; n.rt = rt_in; n.rd = rd_in;
      if (valid_in) begin
        n.valid = 1'b1; n.branch = branch_in; n.memRead = memRead_in;
        n.memToReg = memToReg_in; n.memWrite = memWrite_in; n.aluOp = aluOp_in;
        n.aluSRC = aluSRC_in; n.regWrite = regWrite_in;
      end else begin
        n.valid = 1'b0; n.branch = 1'b0; n.memRead = 1'b0; n.memToReg = 1'b0;
        n.memWrite = 1'b0; n.aluOp = 2'b00; n.aluSRC = 1'b0; n.regWrite = 1'b0;
        n = count_bubble(n);
      end
    end
    return n;
  endfunction

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".valid"},    64'(valid_ex),     64'(e.valid));
    chk({tag, ".branch"},   64'(branch_ex),    64'(e.branch));
    chk({tag, ".memRead"},  64'(memRead_ex),   64'(e.memRead));
    chk({tag, ".memToReg"}, 64'(memToReg_ex),  64'(e.memToReg));
    chk({tag, ".memWrite"}, 64'(memWrite_ex),  64'(e.memWrite));
    chk({tag, ".aluOp"},    64'(aluOp_ex),     64'(e.aluOp));
    chk({tag, ".aluSRC"},   64'(aluSRC_ex),    64'(e.aluSRC));
    chk({tag, ".regWrite"}, 64'(regWrite_ex),  64'(e.regWrite));
    chk({tag, ".pc"},       64'(pc_ex),        64'(e.pc));
    chk({tag, ".rd1"},      64'(readData1_ex), 64'(e.rd1));
    chk({tag, ".rd2"},      64'(readData2_ex), 64'(e.rd2));
    chk({tag, ".imm"},      64'(imm_ex),       64'(e.imm));
    chk({tag, ".rs"},       64'(rs_ex),        64'(e.rs));
    chk({tag, ".rt"},       64'(rt_ex),        64'(e.rt));
    chk({tag, ".rd"},       64'(rd_ex),        64'(e.rd));
    chk({tag, ".cnt"},      64'(bubble_count), 64'(e.cnt));
    chk({tag, ".cnt4"},     64'(d4_bubble_count), 64'(e.cnt4));
    chk({tag, ".d4valid"},  64'(d4_valid_ex),  64'(e.valid));
    if (!e.valid)
      chk({tag, ".ctl_idle"}, 64'({branch_ex, memRead_ex, memToReg_ex, memWrite_ex,
                                   aluOp_ex, aluSRC_ex, regWrite_ex}), 64'd0);
  endtask

  // Push the expectation for the coming edge, then pop and compare 1ns after it.
  task automatic step(input string tag);
    exp_t e;
    model = next_state(model);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    cmp_all(tag, e);
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; valid_in = 0;
    branch_in = 0; memRead_in = 0; memToReg_in = 0; memWrite_in = 0;
    aluOp_in = 2'b00; aluSRC_in = 0; regWrite_in = 0;
    pc_in = '0; readData1_in = '0; readData2_in = '0; imm_in = '0;
    rs_in = '0; rt_in = '0; rd_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt_before;
    rst_n = 1'b0;
    set_idle();
    model = zero_state();
    #2;
    cmp_all("reset", model);
    #1 rst_n = 1'b1;

    // Make the bubble counter and outputs nonzero, then reset mid-run.
    step("bubble0");
    valid_in = 1; regWrite_in = 1; pc_in = 32'h40;
    step("pre_rst");
    chk("pre_rst.regWrite_lit", 64'(regWrite_ex), 64'd1);
    chk("pre_rst.pc_lit", 64'(pc_ex), 64'h40);
    rst_n = 1'b0;
    model = zero_state();
    #2;
    cmp_all("mid_rst", model);
    chk("mid_rst.cnt_lit", 64'(bubble_count), 64'd0);
    #2 rst_n = 1'b1;

    set_idle();
    valid_in = 1; aluOp_in = 2'b10; regWrite_in = 1; readData1_in = 32'h1234; rd_in = 5'd5;
    step("load");
    chk("load.aluOp_lit", 64'(aluOp_ex), 64'h2);
    chk("load.rd1_lit", 64'(readData1_ex), 64'h1234);
    chk("load.rd_lit", 64'(rd_ex), 64'd5);

    cnt_before = bubble_count;
    stall = 1; readData1_in = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.rd1_lit", 64'(readData1_ex), 64'h1234);
      chk("stall.cnt_hold", 64'(bubble_count), 64'(cnt_before));
    end
    readData1_in = 32'hABCD;
    #2;
    chk("no_comb_path", 64'(readData1_ex), 64'h1234);

    flush = 1;
    step("flush_stall");
    chk("flush_stall.cnt_inc", 64'(bubble_count), 64'(cnt_before + 16'd1));
    chk("flush_stall.rd1_lit", 64'(readData1_ex), 64'd0);

    set_idle();
    cnt_before = bubble_count;
    valid_in = 0; memWrite_in = 1; imm_in = 32'h8;
    step("inv_load");
    chk("inv_load.memWrite_lit", 64'(memWrite_ex), 64'd0);
    chk("inv_load.imm_lit", 64'(imm_ex), 64'h8);
    chk("inv_load.cnt_inc", 64'(bubble_count), 64'(cnt_before + 16'd1));

    for (int i = 0; i < 40; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      {branch_in, memRead_in, memToReg_in, memWrite_in, aluSRC_in, regWrite_in} = 6'($urandom);
      aluOp_in = 2'($urandom);
      pc_in = $urandom; readData1_in = $urandom; readData2_in = $urandom; imm_in = $urandom;
      rs_in = 5'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
      step("rand");
    end

    // Saturation on the 4-bit counter instance.
    set_idle();
    rst_n = 1'b0;
    model = zero_state();
    #2 rst_n = 1'b1;
    flush = 1;
    for (int i = 1; i <= 17; i++) begin
      step("sat");
      if (i == 15) chk("sat.cnt4_at15", 64'(d4_bubble_count), 64'hF);
    end
    chk("sat.cnt4_at17", 64'(d4_bubble_count), 64'hF);
    chk("sat.cnt16_at17", 64'(bubble_count), 64'd17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
ID/EX pipeline register for the five-stage datapath. It sits directly downstream of the decode-stage control-bubble mux and the register file. It captures the (possibly bubbled) control bundle plus operand and address fields for one cycle, and presents them to the EX stage. It supports hold (stall), bubble insertion (flush) and a saturating bubble counter for pipeline debug.

Parameters:
DATA_WIDTH, 32, width of register-file operands and immediate
PC_WIDTH, 32, width of the program counter
REG_ADDR_WIDTH, 5, width of rs/rt/rd register indices
CNT_WIDTH, 16, width of the bubble counter

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hold all stage contents this cycle
flush  input  1  load a bubble this cycle
valid_in  input  1  decode-stage instruction is valid
branch_in  input  1  control from bubble mux
memRead_in  input  1  control from bubble mux
memToReg_in  input  1  control from bubble mux
memWrite_in  input  1  control from bubble mux
aluOp_in  input  2  control from bubble mux
aluSRC_in  input  1  control from bubble mux
regWrite_in  input  1  control from bubble mux
pc_in  input  PC_WIDTH  PC+4 of decoded instruction
readData1_in  input  DATA_WIDTH  rs operand
readData2_in  input  DATA_WIDTH  rt operand
imm_in  input  DATA_WIDTH  sign-extended immediate
rs_in, rt_in, rd_in  input  REG_ADDR_WIDTH each  register indices
valid_ex  output  1  EX-stage slot holds a real instruction
branch_ex, memRead_ex, memToReg_ex, memWrite_ex, aluSRC_ex, regWrite_ex  output  1 each  registered control
aluOp_ex  output  2  registered control
pc_ex, readData1_ex, readData2_ex, imm_ex  output  as inputs  registered data
rs_ex, rt_ex, rd_ex  output  REG_ADDR_WIDTH each  registered indices
bubble_count  output  CNT_WIDTH  bubbles inserted since reset

Behaviour:
- Reset: rst_n low clears every output, including bubble_count, to 0 immediately, without waiting for a clock edge. This holds mid-operation too. The first load happens on the first rising edge after rst_n is high.
- All outputs are registered; there is no combinational input-to-output path. Latency is 1 cycle.
- Each rising edge applies exactly one action, in priority order:
  1. flush=1: valid_ex=0; all control outputs=0; all data and index outputs=0. The bubble is counted. flush overrides stall.
  2. stall=1 (flush=0): every output holds its value. The counter holds.
  3. Otherwise, load:
     - valid_in=1: all fields load their inputs; valid_ex=1.
     - valid_in=0: data and index fields load their inputs; all control outputs are forced to 0; valid_ex=0. The bubble is counted.
- Counted bubble: bubble_count increments by 1 and saturates at all-ones. It never wraps.
- Control outputs are never nonzero while valid_ex=0.
- All inputs are sampled only at the clock edge. Input changes between edges have no effect.

Test Plan:
- Reset, then assert rst_n low mid-run while outputs are nonzero (regWrite_ex=1, pc_ex=0x40) -> all outputs 0 before the next edge, bubble_count=0.
- Load with valid_in=1, aluOp_in=2'b10, regWrite_in=1, readData1_in=0x1234, rd_in=5 -> one edge later: valid_ex=1, aluOp_ex=2'b10, regWrite_ex=1, readData1_ex=0x1234, rd_ex=5.
- Load as above, then hold stall=1 for 3 edges while changing inputs to readData1_in=0xFFFF -> outputs stay at readData1_ex=0x1234; bubble_count unchanged.
- flush=1 and stall=1 on the same edge -> valid_ex=0, all control and data outputs 0, bubble_count increments by 1.
- valid_in=0 with memWrite_in=1, imm_in=0x8 -> memWrite_ex=0, valid_ex=0, imm_ex=0x8, bubble_count increments by 1.
- CNT_WIDTH=4: apply 17 consecutive flushes -> bubble_count reaches 4'hF after 15 and stays 4'hF.
